ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-master arbiter in front of the datapath RAM's MFA/MFC handshake port.
//  Master 0 is the control unit's memory path; master 1 is a loader/debug port.
//  Picks one master per access, drives RAM MFA/RW/size/address/data, and
//  returns MFC and read data to the winner only. Round-robin between masters.
// PARAMETERS
//  ADDR_W       8   byte-address width (256-byte RAM)
//  DATA_W       32  data width
//  MFC_TIMEOUT  15  max cycles waiting for ram_mfc (used only with TIMEOUT_EN)
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  Reset      in   1       asynchronous, active-high reset
//  m0_mfa     in   1       master 0 request; hold high until m0_mfc seen
//  m0_rw      in   1       1=write, 0=read
//  m0_size    in   2       00 byte, 01 halfword, 10 word
//  m0_addr    in   ADDR_W  byte address
//  m0_wdata   in   DATA_W  write data
//  m0_mfc     out  1       master 0 access complete
//  m0_rdata   out  DATA_W  master 0 read data (valid while m0_mfc=1)
//  m1_*       --   --      same six signals/widths/meanings for master 1
//  ram_mfa    out  1       RAM memory-function-active
//  ram_rw     out  1       RAM read/write
//  ram_size   out  2       RAM access size
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  ram_mfc    in   1       RAM memory-function-complete
//  grant      out  2       one-hot current owner, 00 when idle
//  err        out  1       sticky timeout flag (0 when TIMEOUT_EN undefined)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, rr pointer favours m0, err=0.
//  - FSM IDLE -> ACCESS -> RELEASE -> IDLE. All outputs registered.
//  - IDLE: mfa sampled high on edge N -> latch rw/size/addr/wdata of winner;
//    after N: grant=winner, ram_mfa=1, state ACCESS.
//  - Both mfa high in IDLE: grant master NOT served last; rr pointer updates on
//    each grant. Single requester always wins regardless of pointer.
//  - ACCESS: ram_* held stable; ram_mfc sampled high on edge M -> after M:
//    ram_mfa=0, mX_rdata=ram_rdata (reads; writes keep previous rdata),
//    mX_mfc=1, state RELEASE.
//  - RELEASE: mX_mfc stays 1 until winner's mfa sampled low on edge P; after
//    P: mfc=0, grant=00, IDLE. Next grant earliest after edge P+1.
//  - Master dropping mfa during ACCESS: access still completes; mfc high for
//    exactly one cycle, then IDLE.
//  - Loser's mfc stays 0 and its rdata unchanged; its request waits in place.
//  - Latched request fields ignore changes on mX_* after the grant edge.
//  - Reset mid-access: immediate return to reset values; RAM access abandoned.
// CONFIGURATION
//  - RAM_ARB_TIMEOUT_EN defined: 4-bit cycle counter runs in ACCESS; when it
//    reaches MFC_TIMEOUT with no ram_mfc: ram_mfa=0, mX_rdata=0, mX_mfc=1,
//    RELEASE, err=1 (sticky until Reset). ram_mfc on the timeout cycle wins.
//  - Undefined: ACCESS waits forever for ram_mfc; err tied 0; no counter.
// TESTING
//  - m0 read word @0x04, RAM mfc after 2 cycles, rdata 0xE3A05005 ->
//    m0_rdata=0xE3A05005, m0_mfc high until m0_mfa drops, grant 01 then 00.
//  - m1 write byte 0xA5 @0x10 -> ram_rw=1, ram_size=00, ram_addr=0x10,
//    ram_wdata=0x000000A5; m0_mfc never asserts.
//  - m0 and m1 both raise mfa after reset -> m0 first, then m1, then
//    repeated joint requests alternate 01,10,01,10.
//  - Change m0_addr 0x20->0x40 during ACCESS -> ram_addr stays 0x20.
//  - Reset asserted in ACCESS -> ram_mfa, grant, mfc all 0 same cycle; next
//    request from m1 with m0 idle is granted.
//  - TIMEOUT_EN, MFC_TIMEOUT=15, ram_mfc never rises -> after 15 ACCESS
//    cycles m0_mfc=1, m0_rdata=0, err=1 and stays 1 until Reset.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Port bundle for ram_arbiter: two request masters, the RAM MFA/MFC port and
// the grant/err status lines.
// Handshake (four-phase, both sides): a requester raises mfa and holds it and
// its rw/size/addr/wdata until it sees mfc; the responder then holds mfc high
// until it samples mfa low. The RAM side follows the same ram_mfa/ram_mfc rules.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m0_mfa;
  logic              m0_rw;
  logic [1:0]        m0_size;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_mfc;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_mfa;
  logic              m1_rw;
  logic [1:0]        m1_size;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_mfc;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_mfa;
  logic              ram_rw;
  logic [1:0]        ram_size;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_mfc;

  logic [1:0]        grant;
  logic              err;

  modport slave (
    input  m0_mfa, m0_rw, m0_size, m0_addr, m0_wdata,
    output m0_mfc, m0_rdata,
    input  m1_mfa, m1_rw, m1_size, m1_addr, m1_wdata,
    output m1_mfc, m1_rdata,
    output ram_mfa, ram_rw, ram_size, ram_addr, ram_wdata,
    input  ram_rdata, ram_mfc,
    output grant, err
  );

  modport master (
    output m0_mfa, m0_rw, m0_size, m0_addr, m0_wdata,
    input  m0_mfc, m0_rdata,
    output m1_mfa, m1_rw, m1_size, m1_addr, m1_wdata,
    input  m1_mfc, m1_rdata,
    input  ram_mfa, ram_rw, ram_size, ram_addr, ram_wdata,
    output ram_rdata, ram_mfc,
    input  grant, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-master arbiter in front of the RAM MFA/MFC port; all outputs
// registered. Optional MFC timeout with sticky err when RAM_ARB_TIMEOUT_EN is defined.
module ram_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          Reset,
  ram_arbiter_if.slave  bus,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ram_mfa_q, ram_mfa_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        mfc_q, mfc_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;
  logic              owner_mfa;
`ifdef RAM_ARB_TIMEOUT_EN
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  assign owner_mfa = owner_q ? bus.m1_mfa : bus.m0_mfa;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rw_d      = rw_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ram_mfa_d = ram_mfa_q;
    grant_d   = grant_q;
    mfc_d     = mfc_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    pick      = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.m0_mfa || bus.m1_mfa) begin
          // Under contention serve the master not served last; a lone requester always wins.
          pick      = (bus.m0_mfa && bus.m1_mfa) ? ~last_q : bus.m1_mfa;
          owner_d   = pick;
          last_d    = pick;
          rw_d      = pick ? bus.m1_rw    : bus.m0_rw;
          size_d    = pick ? bus.m1_size  : bus.m0_size;
          addr_d    = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_d   = pick ? bus.m1_wdata : bus.m0_wdata;
          ram_mfa_d = 1'b1;
          grant_d   = pick ? 2'b10 : 2'b01;
          state_d   = ACCESS;
`ifdef RAM_ARB_TIMEOUT_EN
          cnt_d     = 4'd0;
`endif
        end
      end
      ACCESS: begin
        if (bus.ram_mfc) begin
          ram_mfa_d = 1'b0;
          mfc_d     = owner_q ? 2'b10 : 2'b01;
          if (!rw_q) begin
            if (owner_q) rdata1_d = bus.ram_rdata;
            else         rdata0_d = bus.ram_rdata;
          end
          state_d   = RELEASE;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (cnt_q == 4'(MFC_TIMEOUT - 1)) begin
          ram_mfa_d = 1'b0;
          mfc_d     = owner_q ? 2'b10 : 2'b01;
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
          err_d     = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d     = cnt_q + 4'd1;
        end
`endif
      end
      RELEASE: begin
        if (!owner_mfa) begin
          mfc_d   = 2'b00;
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      rw_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      ram_mfa_q <= 1'b0;
      grant_q   <= 2'b00;
      mfc_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ram_mfa_q <= ram_mfa_d;
      grant_q   <= grant_d;
      mfc_q     <= mfc_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.ram_mfa   = ram_mfa_q;
  assign bus.ram_rw    = rw_q;
  assign bus.ram_size  = size_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.grant     = grant_q;
  assign bus.m0_mfc    = mfc_q[0];
  assign bus.m1_mfc    = mfc_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif
  assign state_o       = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, hand-written corner cases,
// and randomized rounds checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int MFC_TIMEOUT = 15;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [1:0] state_o;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MFC_TIMEOUT(MFC_TIMEOUT)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] exp_rdata [2];
  int          last_srv;            // master served most recently (1 after reset: m0 favoured)
  logic [1:0]  exp_q [$];           // expected grant order, one-hot

  logic        rq_rw    [2];
  logic [1:0]  rq_size  [2];
  logic [7:0]  rq_addr  [2];
  logic [31:0] rq_wdata [2];
  int          rq_hold  [2];

  function automatic logic [31:0] rd_val(input logic [7:0] a);
    if (a == 8'h04) return 32'hE3A05005;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic get_mfc(input int m);
    return (m == 0) ? bus.m0_mfc : bus.m1_mfc;
  endfunction

  function automatic logic [31:0] get_rdata(input int m);
    return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  // ---------------- RAM responder ----------------
  int          ram_lat = 1;
  int          wcnt;
  logic        cap_rw;
  logic [1:0]  cap_size;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata;

  initial begin
    bus.ram_mfc   = 1'b0;
    bus.ram_rdata = '0;
    wcnt          = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.ram_mfc) begin
        bus.ram_mfc = 1'b0;
        wcnt        = 0;
      end else if (bus.ram_mfa) begin
        if (wcnt >= ram_lat) begin
          cap_rw        = bus.ram_rw;
          cap_size      = bus.ram_size;
          cap_addr      = bus.ram_addr;
          cap_wdata     = bus.ram_wdata;
          bus.ram_rdata = bus.ram_rw ? 32'h0BAD0BAD : rd_val(bus.ram_addr);
          bus.ram_mfc   = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int m, input logic v);
    if (m == 0) begin
      bus.m0_mfa   = v;
      bus.m0_rw    = rq_rw[0];
      bus.m0_size  = rq_size[0];
      bus.m0_addr  = rq_addr[0];
      bus.m0_wdata = rq_wdata[0];
    end else begin
      bus.m1_mfa   = v;
      bus.m1_rw    = rq_rw[1];
      bus.m1_size  = rq_size[1];
      bus.m1_addr  = rq_addr[1];
      bus.m1_wdata = rq_wdata[1];
    end
  endtask

  task automatic set_req(input int m, input logic rw, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] wd, input int hold);
    rq_rw[m]    = rw;
    rq_size[m]  = sz;
    rq_addr[m]  = a;
    rq_wdata[m] = wd;
    rq_hold[m]  = hold;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.m0_mfa = 1'b0;
    bus.m1_mfa = 1'b0;
    tick();
    @(negedge CLK);
    Reset = 1'b0;
    last_srv     = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_q.delete();
  endtask

  task automatic wait_mfc(input int m, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (get_mfc(m)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One arbitration round: masters in mask request together; the model predicts order.
  task automatic run_round(input logic [1:0] mask, output logic [1:0] first_grant);
    logic [1:0] pending;
    logic [1:0] exp_g;
    logic       stray;
    int         cyc;
    int         first;
    for (int i = 0; i < 2; i++) if (mask[i]) drive_req(i, 1'b1);
    if (mask == 2'b11) begin
      first = (last_srv == 0) ? 1 : 0;
      exp_q.push_back((first == 0) ? 2'b01 : 2'b10);
      exp_q.push_back((first == 0) ? 2'b10 : 2'b01);
    end else begin
      exp_q.push_back(mask);
    end
    first_grant = 2'b00;
    pending     = mask;
    stray       = 1'b0;
    cyc         = 0;
    while (pending != 2'b00 && cyc < 200) begin
      tick();
      cyc++;
      if (({bus.m1_mfc, bus.m0_mfc} & ~pending) != 2'b00) stray = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (pending[k] && get_mfc(k)) begin
          exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
          if (first_grant == 2'b00) first_grant = bus.grant;
          chk("grant_owner", {30'd0, bus.grant}, {30'd0, exp_g});
          chk("ram_rw",    {31'd0, cap_rw},   {31'd0, rq_rw[k]});
          chk("ram_size",  {30'd0, cap_size}, {30'd0, rq_size[k]});
          chk("ram_addr",  {24'd0, cap_addr}, {24'd0, rq_addr[k]});
          chk("ram_wdata", cap_wdata, rq_wdata[k]);
          if (!rq_rw[k]) exp_rdata[k] = rd_val(rq_addr[k]);
          chk("m0_rdata", bus.m0_rdata, exp_rdata[0]);
          chk("m1_rdata", bus.m1_rdata, exp_rdata[1]);
          last_srv = k;
          repeat (rq_hold[k]) tick();
          chk("mfc_hold", {31'd0, get_mfc(k)}, 32'd1);
          drive_req(k, 1'b0);
          tick();
          chk("mfc_release",   {31'd0, get_mfc(k)}, 32'd0);
          chk("grant_release", {30'd0, bus.grant}, 32'd0);
          pending[k] = 1'b0;
        end
      end
    end
    chk("round_done", {30'd0, pending}, 32'd0);
    chk("stray_mfc",  {31'd0, stray},   32'd0);
    if (pending != 2'b00) begin
      exp_q.delete();
      drive_req(0, 1'b0);
      drive_req(1, 1'b0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          master;
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [1:0]  exp_grant;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // ---------------- main test ----------------
  initial begin
    logic [1:0] fg;
    bit         ok;

    vecs[0] = '{0, 1'b0, 2'b10, 8'h04, 32'h0,        2, 2'b01, 32'hE3A05005};
    vecs[1] = '{1, 1'b1, 2'b00, 8'h10, 32'h000000A5, 1, 2'b10, 32'h00000000};
    vecs[2] = '{1, 1'b0, 2'b01, 8'h22, 32'h0,        0, 2'b10, 32'h22DD78C3};
    vecs[3] = '{0, 1'b1, 2'b10, 8'h80, 32'hDEADBEEF, 3, 2'b01, 32'hE3A05005};
    vecs[4] = '{0, 1'b0, 2'b00, 8'hFF, 32'h0,        0, 2'b01, 32'hFF00A5C3};

    Reset = 1'b1;
    set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 0);
    set_req(1, 1'b0, 2'b00, 8'h00, 32'h0, 0);
    drive_req(0, 1'b0);
    drive_req(1, 1'b0);
    last_srv     = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (2) tick();

    // reset values
    chk("rst_grant",   {30'd0, bus.grant},   32'd0);
    chk("rst_ram_mfa", {31'd0, bus.ram_mfa}, 32'd0);
    chk("rst_mfc",     {30'd0, bus.m1_mfc, bus.m0_mfc}, 32'd0);
    chk("rst_rdata0",  bus.m0_rdata, 32'd0);
    chk("rst_rdata1",  bus.m1_rdata, 32'd0);
    chk("rst_err",     {31'd0, bus.err}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // joint requests right after reset: m0 first, then alternating
    ram_lat = 1;
    set_req(0, 1'b0, 2'b10, 8'h04, 32'h11111111, 1);
    set_req(1, 1'b0, 2'b10, 8'h10, 32'h22222222, 1);
    for (int r = 0; r < 3; r++) begin
      run_round(2'b11, fg);
      chk("joint_first", {30'd0, fg}, 32'd1);
    end

    // vector table
    do_reset();
    foreach (vecs[i]) begin
      ram_lat = vecs[i].lat;
      set_req(vecs[i].master, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, 1);
      run_round((vecs[i].master == 0) ? 2'b01 : 2'b10, fg);
      chk("vec_grant", {30'd0, fg}, {30'd0, vecs[i].exp_grant});
      chk("vec_rdata", get_rdata(vecs[i].master), vecs[i].exp_rdata);
    end

    // latched fields ignore m0_addr changing after the grant edge
    ram_lat = 4;
    set_req(0, 1'b0, 2'b10, 8'h20, 32'h0, 0);
    drive_req(0, 1'b1);
    tick();
    chk("lat_grant", {30'd0, bus.grant}, 32'd1);
    bus.m0_addr = 8'h40;
    tick();
    chk("lat_addr_live", {24'd0, bus.ram_addr}, 32'h20);
    wait_mfc(0, ok);
    chk("lat_mfc_seen", {31'd0, ok}, 32'd1);
    chk("lat_addr_cap", {24'd0, cap_addr}, 32'h20);
    chk("lat_rdata", bus.m0_rdata, rd_val(8'h20));
    exp_rdata[0] = rd_val(8'h20);
    last_srv = 0;
    bus.m0_mfa = 1'b0;
    tick();

    // m1 drops mfa mid-access: access completes, mfc for one cycle only
    ram_lat = 3;
    set_req(1, 1'b0, 2'b10, 8'h33, 32'h0, 0);
    drive_req(1, 1'b1);
    tick();
    chk("drop_grant", {30'd0, bus.grant}, 32'd2);
    drive_req(1, 1'b0);
    wait_mfc(1, ok);
    chk("drop_mfc_seen", {31'd0, ok}, 32'd1);
    chk("drop_rdata", bus.m1_rdata, rd_val(8'h33));
    chk("drop_m0_mfc", {31'd0, bus.m0_mfc}, 32'd0);
    exp_rdata[1] = rd_val(8'h33);
    last_srv = 1;
    tick();
    chk("drop_mfc_1cyc", {31'd0, bus.m1_mfc}, 32'd0);
    chk("drop_grant_0",  {30'd0, bus.grant},  32'd0);

    // reset during ACCESS abandons the access at once
    ram_lat = 1000;
    set_req(0, 1'b0, 2'b10, 8'h50, 32'h0, 0);
    drive_req(0, 1'b1);
    tick();
    chk("ra_grant", {30'd0, bus.grant}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("ra_ram_mfa", {31'd0, bus.ram_mfa}, 32'd0);
    chk("ra_grant0",  {30'd0, bus.grant},   32'd0);
    chk("ra_mfc",     {30'd0, bus.m1_mfc, bus.m0_mfc}, 32'd0);
    drive_req(0, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    last_srv     = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    ram_lat = 1;
    set_req(1, 1'b0, 2'b00, 8'h61, 32'h0, 1);
    run_round(2'b10, fg);
    chk("ra_next_grant", {30'd0, fg}, 32'd2);

    // randomized rounds against the model
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++)
        set_req(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                8'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2));
      ram_lat = $urandom_range(0, 3);
      run_round(2'($urandom_range(1, 3)), fg);
      repeat ($urandom_range(0, 1)) tick();
    end

`ifdef RAM_ARB_TIMEOUT_EN
    // no ram_mfc: timeout after MFC_TIMEOUT ACCESS cycles, sticky err
    do_reset();
    ram_lat = 1000;
    set_req(0, 1'b0, 2'b10, 8'h08, 32'h0, 0);
    drive_req(0, 1'b1);
    tick();
    chk("to_grant", {30'd0, bus.grant}, 32'd1);
    repeat (MFC_TIMEOUT - 1) tick();
    chk("to_not_early", {31'd0, bus.m0_mfc}, 32'd0);
    tick();
    chk("to_mfc",   {31'd0, bus.m0_mfc},  32'd1);
    chk("to_rdata", bus.m0_rdata,          32'd0);
    chk("to_err",   {31'd0, bus.err},      32'd1);
    chk("to_ram_mfa", {31'd0, bus.ram_mfa}, 32'd0);
    drive_req(0, 1'b0);
    tick();
    chk("to_mfc_rel", {31'd0, bus.m0_mfc}, 32'd0);
    last_srv = 0;
    ram_lat = 1;
    set_req(1, 1'b0, 2'b10, 8'h09, 32'h0, 0);
    run_round(2'b10, fg);
    chk("to_err_sticky", {31'd0, bus.err}, 32'd1);
    do_reset();
    tick();
    chk("to_err_cleared", {31'd0, bus.err}, 32'd0);
`else
    chk("err_tied_0", {31'd0, bus.err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
